divider_sequencer: RTL and testbench



---
 rtl/divider_pkg.sv | 19 +
 rtl/div_period_counter.sv | 40 ++++
 rtl/divider_sequencer.sv | 145 ++++++++++++++
 tb/tb_divider_sequencer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/divider_pkg.sv
// -----------------------------------------------------------------------------
// divider_pkg
// Shared definitions for the divide-by-N clock sequencer:
//   state_t     - sequencer states (2-bit encoding)
//   MIN_DIV     - smallest legal divide ratio
//   DEFAULT_DIV - divide ratio in force after reset
// -----------------------------------------------------------------------------
package divider_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_DRAIN = 2'b10
    } state_t;

    localparam int unsigned MIN_DIV     = 2;
    localparam int unsigned DEFAULT_DIV = 3;

endpackage : divider_pkg

// File: rtl/div_period_counter.sv
// -----------------------------------------------------------------------------
// div_period_counter
// Period counter for the divide-by-N generator. Counts 0 .. div_active-1 while
// enabled and flags the last cycle of each period.
//   in_clk     - system clock
//   reset      - asynchronous, active-high reset
//   clear      - synchronous clear to 0 (takes priority over enable)
//   enable     - advance the counter this cycle
//   div_active - ratio in force; period length in cycles (>= 2)
//   count      - current position within the period
//   wrap       - high on the last cycle of a period while enabled
// -----------------------------------------------------------------------------
module div_period_counter #(
    parameter int unsigned W = 8
) (
    input  logic         in_clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         enable,
    input  logic [W-1:0] div_active,
    output logic [W-1:0] count,
    output logic         wrap
);

    // div_active is never below 2, so the subtraction cannot underflow.
    assign wrap = enable && (count == (div_active - W'(1)));

    // NOTE: sequential state is written with non-blocking assignments only, so
    // every register samples pre-edge values regardless of block ordering.
    always_ff @(posedge in_clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= wrap ? '0 : count + W'(1);
        end
    end

endmodule : div_period_counter

// File: rtl/divider_sequencer.sv
// -----------------------------------------------------------------------------
// divider_sequencer
// Run-time controller for the divide-by-N clock generator. Starts/stops the
// divided output and accepts new ratios over a valid/ready handshake; a ratio
// accepted while running is held pending and only applied at a period
// boundary, so no period in flight is ever truncated or stretched.
//   in_clk     - system clock
//   reset      - asynchronous, active-high reset (aborts, drops pending ratio)
//   start      - begin or resume generation
//   stop       - halt at the end of the current period (wins over start)
//   cfg_valid  - new ratio offered on cfg_div
//   cfg_div    - requested divide ratio N
//   cfg_ready  - a ratio can be accepted (no ratio pending)
//   cfg_err    - one-cycle pulse: accepted ratio was < 2 and was discarded
//   out_clk    - divided clock, high for the first floor(N/2) cycles
//   tick       - one-cycle pulse on the first cycle of each period
//   busy       - sequencer is not idle
//   div_active - ratio currently in force
// -----------------------------------------------------------------------------
module divider_sequencer #(
    parameter int unsigned W           = 8,
    parameter int unsigned DEFAULT_DIV = divider_pkg::DEFAULT_DIV
) (
    input  logic         in_clk,
    input  logic         reset,
    input  logic         start,
    input  logic         stop,
    input  logic         cfg_valid,
    input  logic [W-1:0] cfg_div,
    output logic         cfg_ready,
    output logic         cfg_err,
    output logic         out_clk,
    output logic         tick,
    output logic         busy,
    output logic [W-1:0] div_active
);

    import divider_pkg::*;

    localparam logic [W-1:0] DEFAULT_DIV_W = W'(DEFAULT_DIV);
    localparam logic [W-1:0] MIN_DIV_W     = W'(MIN_DIV);

    state_t       state_q;
    state_t       state_d;
    logic [W-1:0] count;
    logic         wrap;
    logic [W-1:0] div_pend;
    logic         pend_flag;
    logic         cfg_xfer;
    logic         ratio_bad;

    // -------------------------------------------------------------------------
    // Period counter: held at 0 in IDLE, free-running in RUN and DRAIN.
    // -------------------------------------------------------------------------
    div_period_counter #(
        .W (W)
    ) u_counter (
        .in_clk     (in_clk),
        .reset      (reset),
        .clear      (state_q == ST_IDLE),
        .enable     (state_q != ST_IDLE),
        .div_active (div_active),
        .count      (count),
        .wrap       (wrap)
    );

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge in_clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic. stop always wins over start. A resume request in
    // DRAIN keeps the counter running, so the output continues without a gap.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: default assignment first so every path assigns state_d and no
        // latch is inferred.
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start && !stop) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (stop) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (start && !stop) state_d = ST_RUN;
                else if (wrap)      state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs, decoded from registers only.
    // -------------------------------------------------------------------------
    always_comb begin
        busy      = (state_q != ST_IDLE);
        tick      = (state_q != ST_IDLE) && (count == '0);
        out_clk   = (state_q != ST_IDLE) && (count < (div_active >> 1));
        cfg_ready = !pend_flag;
    end

    // -------------------------------------------------------------------------
    // Ratio handshake and pending-ratio register.
    // -------------------------------------------------------------------------
    assign cfg_xfer  = cfg_valid && !pend_flag;
    assign ratio_bad = (cfg_div < MIN_DIV_W);

    always_ff @(posedge in_clk or posedge reset) begin
        if (reset) begin
            div_active <= DEFAULT_DIV_W;
            div_pend   <= '0;
            pend_flag  <= 1'b0;
            cfg_err    <= 1'b0;
        end else begin
            cfg_err <= cfg_xfer && ratio_bad;

            // A transfer needs pend_flag == 0, so it can never coincide with
            // applying a pending ratio. A transfer on a wrap cycle therefore
            // only becomes pending and waits for the following wrap.
            if (wrap && pend_flag) begin
                div_active <= div_pend;
                pend_flag  <= 1'b0;
            end

            if (cfg_xfer && !ratio_bad) begin
                if (state_q == ST_IDLE) begin
                    div_active <= cfg_div;
                end else begin
                    div_pend  <= cfg_div;
                    pend_flag <= 1'b1;
                end
            end
        end
    end

endmodule : divider_sequencer

// File: tb/tb_divider_sequencer.sv
// -----------------------------------------------------------------------------
// tb_divider_sequencer
// Self-checking bench for divider_sequencer (W=8, DEFAULT_DIV=3).
// -----------------------------------------------------------------------------
module tb_divider_sequencer;

    localparam int W = 8;

    logic         in_clk = 1'b0;
    logic         reset  = 1'b1;
    logic         start  = 1'b0;
    logic         stop   = 1'b0;
    logic         cfg_valid = 1'b0;
    logic [W-1:0] cfg_div   = '0;
    logic         cfg_ready;
    logic         cfg_err;
    logic         out_clk;
    logic         tick;
    logic         busy;
    logic [W-1:0] div_active;

    divider_sequencer #(
        .W           (W),
        .DEFAULT_DIV (3)
    ) dut (
        .in_clk     (in_clk),
        .reset      (reset),
        .start      (start),
        .stop       (stop),
        .cfg_valid  (cfg_valid),
        .cfg_div    (cfg_div),
        .cfg_ready  (cfg_ready),
        .cfg_err    (cfg_err),
        .out_clk    (out_clk),
        .tick       (tick),
        .busy       (busy),
        .div_active (div_active)
    );

    always #5 in_clk = ~in_clk;

    typedef struct packed {
        logic         busy;
        logic         tick;
        logic         out_clk;
        logic         ready;
        logic         err;
        logic [W-1:0] div;
    } out_t;

    typedef struct {
        logic         start;
        logic         stop;
        logic         cv;
        logic [W-1:0] cd;
        out_t         exp;
    } vec_t;

    vec_t vecs[$];
    out_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic check_out(input string tag, input out_t e);
        check({tag, ".busy"},       busy,       e.busy);
        check({tag, ".tick"},       tick,       e.tick);
        check({tag, ".out_clk"},    out_clk,    e.out_clk);
        check({tag, ".cfg_ready"},  cfg_ready,  e.ready);
        check({tag, ".cfg_err"},    cfg_err,    e.err);
        check({tag, ".div_active"}, div_active, e.div);
    endtask

    // Inputs for one cycle, and the outputs expected after the edge that
    // samples them.
    task automatic add(input logic st, input logic sp, input logic cv, input int cd,
                       input logic b, input logic t, input logic o, input logic r,
                       input logic e, input int d);
        vec_t v;
        v.start = st;
        v.stop  = sp;
        v.cv    = cv;
        v.cd    = W'(cd);
        v.exp   = '{busy: b, tick: t, out_clk: o, ready: r, err: e, div: W'(d)};
        vecs.push_back(v);
    endtask

    task automatic step();
        @(posedge in_clk);
        #1;
    endtask

    initial begin
        out_t e;

        //   st sp cv cd   busy tick oclk rdy err div
        // Start at N=3, rejected ratio 1, then ratio 6 accepted mid-period.
        add(0, 0, 0, 0,   0, 0, 0, 1, 0, 3);
        add(1, 0, 0, 0,   1, 1, 1, 1, 0, 3);
        add(0, 0, 0, 0,   1, 0, 0, 1, 0, 3);
        add(0, 0, 0, 0,   1, 0, 0, 1, 0, 3);
        add(0, 0, 1, 1,   1, 1, 1, 1, 1, 3);
        add(0, 0, 0, 0,   1, 0, 0, 1, 0, 3);
        add(0, 0, 1, 6,   1, 0, 0, 0, 0, 3);
        add(0, 0, 0, 0,   1, 1, 1, 1, 0, 6);
        add(0, 0, 0, 0,   1, 0, 1, 1, 0, 6);
        add(0, 0, 0, 0,   1, 0, 1, 1, 0, 6);
        add(0, 0, 0, 0,   1, 0, 0, 1, 0, 6);
        add(0, 0, 0, 0,   1, 0, 0, 1, 0, 6);
        add(0, 0, 0, 0,   1, 0, 0, 1, 0, 6);
        // Ratio 4 offered on the wrap cycle: held for a full period of 6.
        add(0, 0, 1, 4,   1, 1, 1, 0, 0, 6);
        add(0, 0, 0, 0,   1, 0, 1, 0, 0, 6);
        add(0, 0, 0, 0,   1, 0, 1, 0, 0, 6);
        add(0, 0, 0, 0,   1, 0, 0, 0, 0, 6);
        add(0, 0, 0, 0,   1, 0, 0, 0, 0, 6);
        add(0, 0, 0, 0,   1, 0, 0, 0, 0, 6);
        add(0, 0, 0, 0,   1, 1, 1, 1, 0, 4);
        add(0, 0, 0, 0,   1, 0, 1, 1, 0, 4);
        // Stop at count 1 of N=4: period completes, then idle, no extra tick.
        add(0, 1, 0, 0,   1, 0, 0, 1, 0, 4);
        add(0, 0, 0, 0,   1, 0, 0, 1, 0, 4);
        add(0, 0, 0, 0,   0, 0, 0, 1, 0, 4);
        add(0, 0, 0, 0,   0, 0, 0, 1, 0, 4);
        // start+stop together in IDLE stays idle; ratio 5 in IDLE is immediate.
        add(1, 1, 0, 0,   0, 0, 0, 1, 0, 4);
        add(0, 0, 0, 0,   0, 0, 0, 1, 0, 4);
        add(0, 0, 1, 5,   0, 0, 0, 1, 0, 5);
        // N=5: stop then resume during DRAIN, no gap in periods.
        add(1, 0, 0, 0,   1, 1, 1, 1, 0, 5);
        add(0, 0, 0, 0,   1, 0, 1, 1, 0, 5);
        add(0, 1, 0, 0,   1, 0, 0, 1, 0, 5);
        add(1, 0, 0, 0,   1, 0, 0, 1, 0, 5);
        add(0, 0, 0, 0,   1, 0, 0, 1, 0, 5);
        add(0, 0, 0, 0,   1, 1, 1, 1, 0, 5);
        add(0, 0, 0, 0,   1, 0, 1, 1, 0, 5);
        add(0, 0, 0, 0,   1, 0, 0, 1, 0, 5);
        add(0, 0, 0, 0,   1, 0, 0, 1, 0, 5);
        add(0, 0, 0, 0,   1, 0, 0, 1, 0, 5);
        add(0, 0, 0, 0,   1, 1, 1, 1, 0, 5);
        // Stop with ratio 2 pending: applied on the final DRAIN wrap.
        add(0, 1, 1, 2,   1, 0, 1, 0, 0, 5);
        add(0, 0, 0, 0,   1, 0, 0, 0, 0, 5);
        add(0, 0, 0, 0,   1, 0, 0, 0, 0, 5);
        add(0, 0, 0, 0,   1, 0, 0, 0, 0, 5);
        add(0, 0, 0, 0,   0, 0, 0, 1, 0, 2);
        add(0, 0, 0, 0,   0, 0, 0, 1, 0, 2);
        // Minimum ratio N=2, then ratio 0 rejected in IDLE.
        add(1, 0, 0, 0,   1, 1, 1, 1, 0, 2);
        add(0, 0, 0, 0,   1, 0, 0, 1, 0, 2);
        add(0, 0, 0, 0,   1, 1, 1, 1, 0, 2);
        add(0, 1, 0, 0,   1, 0, 0, 1, 0, 2);
        add(0, 0, 0, 0,   0, 0, 0, 1, 0, 2);
        add(0, 0, 1, 0,   0, 0, 0, 1, 1, 2);
        add(0, 0, 0, 0,   0, 0, 0, 1, 0, 2);

        // Reset state, observed while reset is held.
        repeat (3) @(posedge in_clk);
        #1;
        check_out("reset", '{busy: 0, tick: 0, out_clk: 0, ready: 1, err: 0, div: 8'd3});
        #3 reset = 1'b0;

        // Table: push expectation when driving, pop after the sampling edge.
        for (int i = 0; i < vecs.size(); i++) begin
            start     = vecs[i].start;
            stop      = vecs[i].stop;
            cfg_valid = vecs[i].cv;
            cfg_div   = vecs[i].cd;
            exp_q.push_back(vecs[i].exp);
            step();
            if (exp_q.size() == 0) begin
                check($sformatf("vec%0d.queue_empty", i), 0, 1);
            end else begin
                e = exp_q.pop_front();
                check_out($sformatf("vec%0d", i), e);
            end
        end
        start     = 1'b0;
        stop      = 1'b0;
        cfg_valid = 1'b0;
        check("scoreboard_drained", exp_q.size(), 0);

        // Reset at count 2 of N=6 with ratio 8 pending.
        cfg_valid = 1'b1;
        cfg_div   = 8'd6;
        step();
        cfg_valid = 1'b0;
        check("rst_seq.idle_div6", div_active, 6);
        start = 1'b1;
        step();
        start = 1'b0;
        check("rst_seq.c0_tick", tick, 1);
        step();
        cfg_valid = 1'b1;
        cfg_div   = 8'd8;
        step();
        cfg_valid = 1'b0;
        check("rst_seq.c2_out_clk", out_clk, 1);
        check("rst_seq.c2_ready",   cfg_ready, 0);
        check("rst_seq.c2_div",     div_active, 6);
        #2 reset = 1'b1;
        #1;
        check_out("rst_seq.abort", '{busy: 0, tick: 0, out_clk: 0, ready: 1, err: 0, div: 8'd3});
        @(negedge in_clk);
        reset = 1'b0;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        // Periods of 3 after reset; the dropped ratio 8 must never appear.
        for (int k = 0; k < 7; k++) begin
            check($sformatf("post_rst.k%0d.tick", k),    tick,       (k % 3 == 0) ? 1 : 0);
            check($sformatf("post_rst.k%0d.out_clk", k), out_clk,    (k % 3 == 0) ? 1 : 0);
            check($sformatf("post_rst.k%0d.div", k),     div_active, 3);
            check($sformatf("post_rst.k%0d.busy", k),    busy,       1);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_divider_sequencer
